gon_scan_scheduler: RTL and testbench

- Sequencer for one GON multicast bus. Loads a per-column ID table into the bus's serial ID scan chain, then checks the chain's tail.
- Then steps the broadcast tag through a programmed sequence, advancing after a fixed number of slave handshakes per tag.
- Sits between the top-level config/control logic and the bus's set_id / ID_scan_in / ID_scan_out / tag pins. Observes the bus's slave_valid / slave_ready.

---
 rtl/gon_scan_scheduler.sv | 173 +++++++++++++++++
 tb/tb_gon_scan_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gon_scan_scheduler.sv
// gon_scan_scheduler
//   Sequencer for one GON multicast bus. Shifts a per-column ID table into
//   the bus's serial ID scan chain, verifies the chain tail, then steps the
//   broadcast tag through a programmed sequence, advancing after a fixed
//   number of slave handshakes per tag.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   cfg_we/addr/id        ID table write port (IDLE only, addr < NUMS_MASTER)
//   start                 run request (IDLE only)
//   num_tags              tags to issue              (latched on start)
//   beats_per_tag         handshakes per tag         (latched on start)
//   tag_base              first tag                  (latched on start)
//   ID_scan_out           scan chain tail
//   slave_valid/ready     bus output handshake
//   set_id, ID_scan_in    scan chain shift enable / head data
//   tag                   current broadcast tag
//   busy, done, scan_err  status: not idle / one-cycle end pulse / sticky scan mismatch
module gon_scan_scheduler #(
    parameter int NUMS_MASTER = 6,
    parameter int ID_SIZE     = 4,
    parameter int ADDR_W      = 3,
    parameter int TAGN_W      = 8,
    parameter int BEAT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ID_SIZE-1:0] cfg_id,
    input  logic               start,
    input  logic [TAGN_W-1:0]  num_tags,
    input  logic [BEAT_W-1:0]  beats_per_tag,
    input  logic [ID_SIZE-1:0] tag_base,
    input  logic [ID_SIZE-1:0] ID_scan_out,
    input  logic               slave_valid,
    input  logic               slave_ready,
    output logic               set_id,
    output logic [ID_SIZE-1:0] ID_scan_in,
    output logic [ID_SIZE-1:0] tag,
    output logic               busy,
    output logic               done,
    output logic               scan_err
);

    typedef enum logic [2:0] {IDLE, SCAN, CHECK, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUMS_MASTER - 1);
    localparam logic [ADDR_W:0]   NM_W = (ADDR_W + 1)'(NUMS_MASTER);

    state_t             state, state_d;
    logic [ID_SIZE-1:0] id_tbl [NUMS_MASTER];
    logic [ADDR_W-1:0]  scan_cnt, scan_cnt_d;
    logic [BEAT_W-1:0]  beat_cnt, beat_cnt_d, beats_q;
    logic [TAGN_W-1:0]  tag_idx, tag_idx_d, num_tags_q;
    logic [ID_SIZE-1:0] tag_base_q, tag_d, id_in_d;
    logic               set_id_d, scan_err_d, latch, tbl_we, hs;

    assign hs = slave_valid & slave_ready;

    always_comb begin
        state_d    = state;
        scan_cnt_d = scan_cnt;
        beat_cnt_d = beat_cnt;
        tag_idx_d  = tag_idx;
        tag_d      = tag;
        scan_err_d = scan_err;
        set_id_d   = 1'b0;
        id_in_d    = '0;
        latch      = 1'b0;
        tbl_we     = 1'b0;
        case (state)
            IDLE: begin
                tbl_we = cfg_we && ({1'b0, cfg_addr} < NM_W);
                if (start) begin
                    state_d    = SCAN;
                    scan_cnt_d = '0;
                    scan_err_d = 1'b0;
                    latch      = 1'b1;
                    set_id_d   = 1'b1;
                    // The first shifted entry is registered on the start edge,
                    // so a same-cycle write to the last column is forwarded.
                    id_in_d    = (tbl_we && cfg_addr == LAST) ? cfg_id : id_tbl[LAST];
                end
            end
            SCAN: begin
                if (scan_cnt == LAST) begin
                    state_d = CHECK;
                end else begin
                    scan_cnt_d = scan_cnt + ADDR_W'(1);
                    set_id_d   = 1'b1;
                    id_in_d    = id_tbl[LAST - scan_cnt - ADDR_W'(1)];
                end
            end
            CHECK: begin
                if (ID_scan_out != id_tbl[LAST]) begin
                    scan_err_d = 1'b1;
                    state_d    = DONE;
                end else if (num_tags_q == '0 || beats_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d    = RUN;
                    tag_d      = tag_base_q;
                    beat_cnt_d = '0;
                    tag_idx_d  = '0;
                end
            end
            RUN: begin
                if (hs) begin
                    if (beat_cnt == beats_q - BEAT_W'(1)) begin
                        beat_cnt_d = '0;
                        if (tag_idx == num_tags_q - TAGN_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            tag_d     = tag + ID_SIZE'(1);
                            tag_idx_d = tag_idx + TAGN_W'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt   <= '0;
            beat_cnt   <= '0;
            tag_idx    <= '0;
            num_tags_q <= '0;
            beats_q    <= '0;
            tag_base_q <= '0;
            set_id     <= 1'b0;
            ID_scan_in <= '0;
            tag        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            scan_err   <= 1'b0;
        end else begin
            scan_cnt   <= scan_cnt_d;
            beat_cnt   <= beat_cnt_d;
            tag_idx    <= tag_idx_d;
            set_id     <= set_id_d;
            ID_scan_in <= id_in_d;
            tag        <= tag_d;
            busy       <= (state_d != IDLE);
            done       <= (state_d == DONE);
            scan_err   <= scan_err_d;
            if (latch) begin
                num_tags_q <= num_tags;
                beats_q    <= beats_per_tag;
                tag_base_q <= tag_base;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUMS_MASTER; i++) id_tbl[i] <= '0;
        end else if (tbl_we) begin
            id_tbl[cfg_addr] <= cfg_id;
        end
    end

endmodule

// File: tb/tb_gon_scan_scheduler.sv
// Testbench for gon_scan_scheduler: models the 6-stage scan chain and scores
// scan data and per-handshake tags against queued expectations.
module tb_gon_scan_scheduler;

    localparam int NM  = 6;
    localparam int IDW = 4;
    localparam int AW  = 3;
    localparam int TW  = 8;
    localparam int BW  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [IDW-1:0] cfg_id = '0;
    logic           start = 1'b0;
    logic [TW-1:0]  num_tags = '0;
    logic [BW-1:0]  beats_per_tag = '0;
    logic [IDW-1:0] tag_base = '0;
    logic [IDW-1:0] ID_scan_out;
    logic           slave_valid = 1'b0;
    logic           slave_ready = 1'b0;
    logic           set_id;
    logic [IDW-1:0] ID_scan_in;
    logic [IDW-1:0] tag;
    logic           busy, done, scan_err;

    gon_scan_scheduler #(
        .NUMS_MASTER(NM), .ID_SIZE(IDW), .ADDR_W(AW), .TAGN_W(TW), .BEAT_W(BW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_id(cfg_id),
        .start(start), .num_tags(num_tags), .beats_per_tag(beats_per_tag),
        .tag_base(tag_base), .ID_scan_out(ID_scan_out), .slave_valid(slave_valid),
        .slave_ready(slave_ready), .set_id(set_id), .ID_scan_in(ID_scan_in),
        .tag(tag), .busy(busy), .done(done), .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    // Scan chain model: column 0 is the head, column NM-1 the tail.
    logic [IDW-1:0] chain [NM];
    logic           force_zero = 1'b0;
    always @(posedge clk) begin
        if (set_id) begin
            for (int i = NM - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= ID_scan_in;
        end
    end
    assign ID_scan_out = force_zero ? '0 : chain[NM-1];

    int errors = 0;
    int checks = 0;
    logic [IDW-1:0] exp_q [$];
    logic [IDW-1:0] tbl_model [NM];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int addr, input int id);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_id = IDW'(id);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({set_id, ID_scan_in, tag, busy, done, scan_err} !== '0)
            $display("FAIL reset_outputs: got %b expected all zero",
                     {set_id, ID_scan_in, tag, busy, done, scan_err});
        if ({set_id, ID_scan_in, tag, busy, done, scan_err} !== '0) errors++;
        for (int i = 0; i < NM; i++) tbl_model[i] = '0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Optionally loads table 1..NM (last entry written together with start),
    // runs a zero-tag sequence and scores the shifted data.
    task automatic test_scan(input bit do_write);
        int nset, ndone, done_at;
        logic [IDW-1:0] e, tag0;
        if (do_write) begin
            for (int i = 0; i < NM - 1; i++) begin
                write_tbl(i, i + 1);
                tbl_model[i] = IDW'(i + 1);
            end
            tbl_model[NM-1] = IDW'(NM);
        end
        exp_q.delete();
        for (int k = 0; k < NM; k++) exp_q.push_back(tbl_model[NM-1-k]);
        tag0 = tag;
        num_tags = '0; beats_per_tag = 16'd1; tag_base = 4'd5;
        start = 1'b1;
        if (do_write) begin
            cfg_we = 1'b1; cfg_addr = AW'(NM - 1); cfg_id = IDW'(NM);
        end
        tick();
        start = 1'b0; cfg_we = 1'b0;
        nset = 0; ndone = 0; done_at = -1;
        for (int c = 0; c < 12; c++) begin
            if (set_id) begin
                nset++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scan_extra: set_id high in cycle %0d, expected low", c);
                end else begin
                    e = exp_q.pop_front();
                    if (ID_scan_in !== e) begin
                        errors++;
                        $display("FAIL scan_data: cycle %0d got %0d expected %0d", c, ID_scan_in, e);
                    end
                end
            end
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            checks++;
            if (tag !== tag0) begin
                errors++;
                $display("FAIL scan_tag_hold: got %0d expected %0d", tag, tag0);
            end
            tick();
        end
        checks++;
        if (nset != NM) begin
            errors++;
            $display("FAIL scan_len: got %0d expected %0d", nset, NM);
        end
        checks++;
        if (done_at != NM + 1 || ndone != 1) begin
            errors++;
            $display("FAIL scan_done: at %0d count %0d expected at %0d count 1", done_at, ndone, NM + 1);
        end
        checks++;
        if (scan_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL scan_status: scan_err %b busy %b expected 0 0", scan_err, busy);
        end
        for (int i = 0; i < NM; i++) begin
            checks++;
            if (chain[i] !== tbl_model[i]) begin
                errors++;
                $display("FAIL chain_col%0d: got %0d expected %0d", i, chain[i], tbl_model[i]);
            end
        end
    endtask

    task automatic test_scan_err;
        int ndone, bad_tag;
        logic err_at_done;
        force_zero = 1'b1;
        slave_valid = 1'b1; slave_ready = 1'b1;
        num_tags = 8'd3; beats_per_tag = 16'd1; tag_base = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; bad_tag = 0; err_at_done = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (tag !== 4'd0) bad_tag++;
            if (done) begin
                ndone++;
                err_at_done = scan_err;
            end
            tick();
        end
        slave_valid = 1'b0; slave_ready = 1'b0;
        force_zero = 1'b0;
        checks++;
        if (ndone != 1 || err_at_done !== 1'b1) begin
            errors++;
            $display("FAIL err_done: done count %0d scan_err %b expected 1 1", ndone, err_at_done);
        end
        checks++;
        if (bad_tag != 0) begin
            errors++;
            $display("FAIL err_tag: %0d cycles with tag nonzero, expected 0", bad_tag);
        end
        checks++;
        if (scan_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", scan_err);
        end
        num_tags = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (scan_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", scan_err);
        end
        for (int c = 0; c < 20 && busy; c++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL err_rerun_timeout: busy %b expected 0", busy);
        end
    endtask

    task automatic run_tags(input logic [IDW-1:0] base, input int nt, input int bpt, input bit disturb);
        int total, hs;
        logic [IDW-1:0] e, last;
        exp_q.delete();
        for (int t = 0; t < nt; t++)
            for (int b = 0; b < bpt; b++) exp_q.push_back(base + IDW'(t));
        total = nt * bpt;
        last = base + IDW'(nt - 1);
        num_tags = TW'(nt); beats_per_tag = BW'(bpt); tag_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < NM + 1; c++) begin
            if (disturb && c == 2) begin
                start = 1'b1; tag_base = 4'd9; num_tags = 8'd7; beats_per_tag = 16'd3;
                cfg_we = 1'b1; cfg_addr = '0; cfg_id = 4'd15;
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            tick();
        end
        start = 1'b0; cfg_we = 1'b0;
        checks++;
        if ({busy, done, set_id, tag} !== {1'b1, 1'b0, 1'b0, base}) begin
            errors++;
            $display("FAIL run_entry: busy/done/set_id/tag got %b expected %b",
                     {busy, done, set_id, tag}, {1'b1, 1'b0, 1'b0, base});
        end
        hs = 0;
        for (int c = 0; c < 400 && hs < total; c++) begin
            slave_valid = ($urandom_range(0, 3) != 0);
            slave_ready = ($urandom_range(0, 2) != 0);
            if (disturb && c == 0) begin
                start = 1'b1; num_tags = 8'd1;
                cfg_we = 1'b1; cfg_addr = 3'd1; cfg_id = 4'd14;
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL run_early_done: got %b expected 0 after %0d handshakes", done, hs);
            end
            if (slave_valid && slave_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (tag !== e) begin
                    errors++;
                    $display("FAIL run_tag: handshake %0d got %0d expected %0d", hs, tag, e);
                end
                hs++;
            end
            tick();
        end
        slave_valid = 1'b0; slave_ready = 1'b0; start = 1'b0; cfg_we = 1'b0;
        checks++;
        if (hs < total) begin
            errors++;
            $display("FAIL run_timeout: got %0d handshakes expected %0d", hs, total);
        end
        checks++;
        if (done !== 1'b1 || tag !== last) begin
            errors++;
            $display("FAIL run_done: done %b tag %0d expected 1 %0d", done, tag, last);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || tag !== last) begin
            errors++;
            $display("FAIL run_idle: done %b busy %b tag %0d expected 0 0 %0d", done, busy, tag, last);
        end
    endtask

    task automatic test_tag_sequence;
        run_tags(4'd2, 3, 2, 1'b0);
    endtask

    task automatic test_tag_wrap;
        run_tags(4'd15, 2, 1, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        run_tags(4'd3, 2, 1, 1'b1);
        test_scan(1'b0);
    endtask

    task automatic test_reset_mid_run;
        num_tags = 8'd3; beats_per_tag = 16'd2; tag_base = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < NM + 1; c++) tick();
        slave_valid = 1'b1; slave_ready = 1'b1;
        tick();
        tick();
        slave_valid = 1'b0; slave_ready = 1'b0;
        checks++;
        if (tag !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_tag: tag %0d busy %b expected 2 1", tag, busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({set_id, ID_scan_in, tag, busy, done, scan_err} !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: got %b expected all zero",
                     {set_id, ID_scan_in, tag, busy, done, scan_err});
        end
        for (int i = 0; i < NM; i++) tbl_model[i] = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        test_scan(1'b1);
    endtask

    initial begin
        test_reset();
        test_scan(1'b1);
        test_scan_err();
        test_tag_sequence();
        test_tag_wrap();
        test_ignored_inputs();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
